// File: rtl/exception_rstatus_queue.sv
// Fixed-priority exception arbiter feeding a small FIFO that drains status
// codes into the RSTATUS register through a valid/ready writeback port.
// Also provides a one-cycle flush per accepted exception and sticky
// drop/overflow status.
module exception_rstatus_queue #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned CODE_W      = 8,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned RSTATUS_REG = 30
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        exc_enable,
  input  logic [NUM_SRC-1:0]          exc_valid,
  input  logic [NUM_SRC*CODE_W-1:0]   exc_code,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [ADDR_W-1:0]           wb_addr,
  output logic [WIDTH-1:0]            wb_data,
  output logic                        flush,
  output logic                        overflow,
  input  logic                        clear_ovf,
  output logic [7:0]                  drop_count,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              flush_q, flush_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_q, drop_d;

  logic              req;
  logic [CODE_W-1:0] win_code;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              drop;

  // Fixed-priority arbitration: lowest set channel index wins
  always_comb begin
    win_code = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (exc_valid[i-1]) begin
        win_code = exc_code[(i-1)*CODE_W +: CODE_W];
      end
    end
    req = exc_enable & (|exc_valid);
  end

  assign full     = (occ_q == CNT_W'(DEPTH));
  assign empty    = (occ_q == '0);
  assign wb_valid = ~empty;
  assign pop      = wb_valid & wb_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push     = req & (~full | pop);
  assign drop     = req & full & ~pop;

  assign wb_addr    = ADDR_W'(RSTATUS_REG);
  assign wb_data    = empty ? '0 : WIDTH'(mem_q[rd_ptr_q]);
  assign flush      = flush_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign occupancy  = occ_q;

  // Next-state for storage, pointers, fill level and status
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q + CNT_W'(push) - CNT_W'(pop);
    flush_d    = push;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (push) begin
      mem_d[wr_ptr_q] = win_code;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Clear takes precedence over a drop in the same cycle
    if (clear_ovf) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != '1) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      flush_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      flush_q    <= flush_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_exception_rstatus_queue.sv
// Testbench for exception_rstatus_queue: directed scenarios followed by
// random traffic, checked against a queue-based reference model.
module tb_exception_rstatus_queue;

  logic        clock;
  logic        reset_n;
  logic        exc_enable;
  logic [3:0]  exc_valid;
  logic [31:0] exc_code;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        overflow;
  logic        clear_ovf;
  logic [7:0]  drop_count;
  logic [1:0]  occupancy;

  exception_rstatus_queue #(
    .WIDTH(32), .NUM_SRC(4), .CODE_W(8), .DEPTH(2), .ADDR_W(5), .RSTATUS_REG(30)
  ) dut (
    .clock(clock), .reset_n(reset_n), .exc_enable(exc_enable),
    .exc_valid(exc_valid), .exc_code(exc_code), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .overflow(overflow), .clear_ovf(clear_ovf), .drop_count(drop_count),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model: FIFO contents as a queue plus status values
  int          mq[$];
  bit          m_flush;
  bit          m_ovf;
  int          m_drops;
  logic [7:0]  codes [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_codes(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
    codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
    exc_code = {c3, c2, c1, c0};
  endtask

  task automatic model_reset();
    mq.delete();
    m_flush = 0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ":wb_valid"},   32'(wb_valid),   32'(mq.size() > 0));
    chk({where, ":wb_data"},    wb_data,         (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    chk({where, ":wb_addr"},    32'(wb_addr),    32'd30);
    chk({where, ":flush"},      32'(flush),      32'(m_flush));
    chk({where, ":overflow"},   32'(overflow),   32'(m_ovf));
    chk({where, ":drop_count"}, 32'(drop_count), 32'(m_drops));
    chk({where, ":occupancy"},  32'(occupancy),  32'(mq.size()));
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model
  task automatic step(input string where, input logic en, input logic [3:0] v,
                      input logic rdy, input logic clr);
    bit req, pop, accepted;
    int win;
    exc_enable = en;
    exc_valid  = v;
    wb_ready   = rdy;
    clear_ovf  = clr;
    @(negedge clock);
    check_outputs(where);
    req = en && (v != 4'd0);
    win = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) win = i;
    pop = (mq.size() > 0) && rdy;
    accepted = req && ((mq.size() < 2) || pop);
    if (pop) void'(mq.pop_front());
    if (accepted) mq.push_back(int'(codes[win]));
    m_flush = accepted;
    if (clr) begin
      m_ovf = 0;
      m_drops = 0;
    end else if (req && !accepted) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; exc_enable = 1'b1; exc_valid = '0; wb_ready = 1'b0; clear_ovf = 1'b0;
    set_codes(8'd1, 8'd2, 8'd3, 8'd4);
    model_reset();
    #2;
    check_outputs("reset");
    #20 reset_n = 1'b1;
    @(posedge clock); #1;

    // Idle after reset
    for (int i = 0; i < 10; i++) step("idle", 1, 4'b0000, 1, 0);

    // Two simultaneous channels: ch1 wins, one entry, immediate drain
    step("dual_req", 1, 4'b0110, 1, 0);
    chk("dual_req:head_is_2", wb_data, 32'd2);
    step("dual_drain", 1, 4'b0000, 1, 0);
    step("dual_empty", 1, 4'b0000, 1, 0);

    // Stall and overfill: ch2, ch0 stored, ch3 dropped
    step("stall_ch2", 1, 4'b0100, 0, 0);
    step("stall_ch0", 1, 4'b0001, 0, 0);
    step("stall_ch3", 1, 4'b1000, 0, 0);
    chk("stall:drop_count_1", 32'(drop_count), 32'd1);
    chk("stall:head_is_3", wb_data, 32'd3);
    for (int i = 0; i < 4; i++) step("stall_drain", 1, 4'b0000, 1, 0);

    // Full with simultaneous pop and push: no drop, ch3 code queued last
    step("clr_before_full", 1, 4'b0000, 0, 1);
    step("full_a", 1, 4'b0010, 0, 0);
    step("full_b", 1, 4'b0001, 0, 0);
    step("full_pushpop", 1, 4'b1000, 1, 0);
    chk("full_pushpop:no_drop", 32'(drop_count), 32'd0);
    chk("full_pushpop:occ_2", 32'(occupancy), 32'd2);
    for (int i = 0; i < 3; i++) step("full_drain", 1, 4'b0000, 1, 0);

    // Saturating drop counter, then clear
    step("sat_fill_a", 1, 4'b0001, 0, 0);
    step("sat_fill_b", 1, 4'b0010, 0, 0);
    for (int i = 0; i < 300; i++) step("sat_drop", 1, 4'b0100, 0, 0);
    chk("sat:drop_count_255", 32'(drop_count), 32'd255);
    step("sat_clear_vs_drop", 1, 4'b0100, 0, 1);
    step("sat_after_clear", 1, 4'b0000, 0, 0);
    chk("sat:cleared", 32'(drop_count), 32'd0);

    // Asynchronous reset mid-drain with occupancy 2
    wb_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst:wb_valid", 32'(wb_valid), 32'd0);
    chk("async_rst:occupancy", 32'(occupancy), 32'd0);
    chk("async_rst:wb_data", wb_data, 32'd0);
    model_reset();
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) step("post_rst", 1, 4'b0000, 1, 0);

    // Disabled capture with all channels requesting
    for (int i = 0; i < 3; i++) step("disabled", 0, 4'hF, 1, 0);
    // Draining continues while disabled
    step("en_fill", 1, 4'b1000, 0, 0);
    step("dis_drain", 0, 4'hF, 1, 0);
    step("dis_empty", 0, 4'hF, 1, 0);

    // Random traffic with random codes
    set_codes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0)
        set_codes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      step("random", ($urandom_range(0, 9) != 0), 4'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 30) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound so the bench always ends
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
